id_stage: RTL

Instruction decode stage of the PandaZero five-stage pipeline. It sits directly downstream of the instruction fetch stage and consumes its valid/instr/pc bundle under the same valid/ack handshake. It decodes RV32I, reads the register file and blocks read-after-write hazards with a per-register scoreboard. It presents a registered decoded bundle to the execute stage and owns the architectural register file, which is written from the writeback port.

---
 rtl/core_pkg.sv | 53 +++++
 rtl/regfile.sv | 31 +++
 rtl/id_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared ALU op encoding, RV32I opcodes and the ID/EX register layout.
package core_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        alu_op_t     alu_op;
        logic [2:0]  funct3;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        use_pc;
        logic        use_imm;
        logic        wb_en;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jump;
        logic        illegal;
    } id_ex_t;

    // alt is funct7[5]; it selects SUB only for register-register ops
    function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt, input logic sub_ok);
        case (f3)
            3'd0:    return (alt && sub_ok) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// regfile: 31x32 register file, two combinational read ports with write-through, x0 hardwired to zero.
module regfile (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o
);

    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];

    always_comb begin
        regs_d = regs_q;
        if (we_i && waddr_i != 5'd0) regs_d[waddr_i] = wdata_i;
    end

    // reading the next-state array gives same-cycle write-through for free
    assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_d[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_d[raddr_b_i];

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) regs_q <= '{default: '0};
        else         regs_q <= regs_d;
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode, register read and scoreboard hazard stall feeding a registered ID/EX bundle.
module id_stage
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        flush_i,
    input  logic        halt_i,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        ack_o,
    output logic        valid_o,
    input  logic        ack_i,
    output logic [3:0]  alu_op_o,
    output logic [2:0]  funct3_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic [31:0] pc_o,
    output logic [4:0]  rd_o,
    output logic        use_pc_o,
    output logic        use_imm_o,
    output logic        wb_en_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic        branch_o,
    output logic        jump_o,
    output logic        illegal_o,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i
);

    id_ex_t      dec, out_q, out_d;
    logic        valid_q, valid_d;
    logic [31:0] busy_q, busy_d;
    logic [31:0] rs1_rdata, rs2_rdata;
    logic [31:0] need_mask, clr_mask, squash_mask;
    logic        use_rs1, use_rs2, stall;

    wire [6:0]  opcode = instr_i[6:0];
    wire [4:0]  rs1    = instr_i[19:15];
    wire [4:0]  rs2    = instr_i[24:20];
    wire [31:0] imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    wire [31:0] imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    wire [31:0] imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    wire [31:0] imm_u  = {instr_i[31:12], 12'd0};
    wire [31:0] imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    regfile u_regfile (
        .clk       (clk),
        .rstn_i    (rstn_i),
        .we_i      (wb_valid_i),
        .waddr_i   (wb_rd_i),
        .wdata_i   (wb_data_i),
        .raddr_a_i (rs1),
        .raddr_b_i (rs2),
        .rdata_a_o (rs1_rdata),
        .rdata_b_o (rs2_rdata)
    );

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        dec.funct3 = instr_i[14:12];
        dec.pc     = pc_i;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        case (opcode)
            OPC_LUI:    begin dec.alu_op = ALU_PASS_B; dec.imm = imm_u; dec.use_imm = 1'b1; dec.wb_en = 1'b1; end
            OPC_AUIPC:  begin dec.imm = imm_u; dec.use_pc = 1'b1; dec.use_imm = 1'b1; dec.wb_en = 1'b1; end
            OPC_JAL:    begin dec.imm = imm_j; dec.use_pc = 1'b1; dec.use_imm = 1'b1; dec.wb_en = 1'b1; dec.jump = 1'b1; end
            OPC_JALR:   begin dec.imm = imm_i; dec.use_imm = 1'b1; dec.wb_en = 1'b1; dec.jump = 1'b1; use_rs1 = 1'b1; end
            OPC_BRANCH: begin dec.imm = imm_b; dec.use_pc = 1'b1; dec.use_imm = 1'b1; dec.branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_LOAD:   begin dec.imm = imm_i; dec.use_imm = 1'b1; dec.wb_en = 1'b1; dec.mem_rd = 1'b1; use_rs1 = 1'b1; end
            OPC_STORE:  begin dec.imm = imm_s; dec.use_imm = 1'b1; dec.mem_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_OPIMM:  begin dec.alu_op = alu_sel(instr_i[14:12], instr_i[30], 1'b0); dec.imm = imm_i; dec.use_imm = 1'b1; dec.wb_en = 1'b1; use_rs1 = 1'b1; end
            OPC_OP:     begin dec.alu_op = alu_sel(instr_i[14:12], instr_i[30], 1'b1); dec.wb_en = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_FENCE:  ;
            OPC_SYSTEM: dec.illegal = 1'b1;
            default:    dec.illegal = 1'b1;
        endcase
        dec.rd       = dec.wb_en ? instr_i[11:7] : 5'd0;
        dec.rs1_data = rs1_rdata;
        dec.rs2_data = rs2_rdata;
    end

    // a busy register retiring this very cycle does not block; rd is included so WAW also stalls
    always_comb begin
        need_mask   = ((use_rs1 ? 32'd1 << rs1 : 32'd0) | (use_rs2 ? 32'd1 << rs2 : 32'd0) | (32'd1 << dec.rd)) & ~32'd1;
        clr_mask    = wb_valid_i ? 32'd1 << wb_rd_i : 32'd0;
        squash_mask = (flush_i && valid_q) ? 32'd1 << out_q.rd : 32'd0;
        stall       = |(need_mask & busy_q & ~clr_mask);
        busy_d      = ((busy_q & ~clr_mask & ~squash_mask) | (ack_o ? 32'd1 << dec.rd : 32'd0)) & ~32'd1;
        valid_d     = flush_i ? 1'b0 : halt_i ? valid_q : ack_o ? 1'b1 : ack_i ? 1'b0 : valid_q;
        out_d       = ack_o ? dec : out_q;
    end

    assign ack_o = rstn_i && valid_i && !stall && (!valid_q || ack_i) && !halt_i && !flush_i;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            out_q   <= '0;
            busy_q  <= '0;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign valid_o    = valid_q;
    assign alu_op_o   = out_q.alu_op;
    assign funct3_o   = out_q.funct3;
    assign rs1_data_o = out_q.rs1_data;
    assign rs2_data_o = out_q.rs2_data;
    assign imm_o      = out_q.imm;
    assign pc_o       = out_q.pc;
    assign rd_o       = out_q.rd;
    assign use_pc_o   = out_q.use_pc;
    assign use_imm_o  = out_q.use_imm;
    assign wb_en_o    = out_q.wb_en;
    assign mem_rd_o   = out_q.mem_rd;
    assign mem_wr_o   = out_q.mem_wr;
    assign branch_o   = out_q.branch;
    assign jump_o     = out_q.jump;
    assign illegal_o  = out_q.illegal;

endmodule
